// File: rtl/channel_demultiplexer.sv
// Receive-side GLIP demultiplexer: decodes the in-band c001/ab control protocol and routes payload
// words to one of CHANN channels through a single output register. Optional counters: CHANNEL_DEMUX_STATS_EN.
module channel_demultiplexer #(
    parameter int WIDTH = 16,
    parameter int CHANN = 8
) (
    input  logic                     clk,
    input  logic                     com_rst,
    input  logic                     fifo_in_valid,
    output logic                     fifo_in_ready,
    input  logic [WIDTH-1:0]         fifo_in_data,
    output logic [CHANN-1:0]         fifo_in_valid_channel,
    input  logic [CHANN-1:0]         fifo_in_ready_channel,
    output logic [CHANN*WIDTH-1:0]   fifo_in_data_channel,
    output logic                     protocol_err
`ifdef CHANNEL_DEMUX_STATS_EN
    ,
    output logic [15:0]              drop_count,
    output logic [CHANN*16-1:0]      word_count
`endif
);

    localparam int CW = (CHANN > 1) ? $clog2(CHANN) : 1;
    localparam logic [8:0] CHANN_LIM = 9'(CHANN);
    localparam logic [WIDTH-1:0] CTRL_WORD = WIDTH'(16'hc001);

    localparam logic [1:0] ST_UNSEL = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_CTRL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       saved_q, saved_d;
    logic [CW-1:0]    channel_q, channel_d;
    logic             out_valid_q;
    logic [CW-1:0]    out_chan_q;
    logic [WIDTH-1:0] out_data_q;
    logic             err_q;

    logic accept, drain, emit, err, drop;
    logic is_ctrl, is_hdr, hdr_ok;

    assign drain         = out_valid_q && fifo_in_ready_channel[out_chan_q];
    // Every word, control included, waits for the output stage so channels never reorder.
    assign fifo_in_ready = !out_valid_q || fifo_in_ready_channel[out_chan_q];
    assign accept        = fifo_in_valid && fifo_in_ready;

    assign is_ctrl = (fifo_in_data == CTRL_WORD);
    assign is_hdr  = (fifo_in_data[15:8] == 8'hab);
    assign hdr_ok  = ({1'b0, fifo_in_data[7:0]} < CHANN_LIM);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        saved_d   = saved_q;
        channel_d = channel_q;
        emit      = 1'b0;
        err       = 1'b0;
        drop      = 1'b0;
        case (state_q)
            ST_CTRL: begin
                if (is_ctrl) begin
                    state_d = saved_q;
                    if (saved_q == ST_DATA) begin
                        emit = 1'b1;
                    end else begin
                        err  = 1'b1;
                        drop = 1'b1;
                    end
                end else if (is_hdr) begin
                    if (hdr_ok) begin
                        channel_d = fifo_in_data[CW-1:0];
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_UNSEL;
                        err     = 1'b1;
                    end
                end else begin
                    state_d = saved_q;
                    err     = 1'b1;
                end
            end
            ST_DATA: begin
                if (is_ctrl) begin
                    saved_d = ST_DATA;
                    state_d = ST_CTRL;
                end else begin
                    emit = 1'b1;
                end
            end
            default: begin
                if (is_ctrl) begin
                    saved_d = ST_UNSEL;
                    state_d = ST_CTRL;
                end else begin
                    err  = 1'b1;
                    drop = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (com_rst) begin
            state_q   <= ST_UNSEL;
            saved_q   <= ST_UNSEL;
            channel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept && err;
            if (accept) begin
                state_q   <= state_d;
                saved_q   <= saved_d;
                channel_q <= channel_d;
            end
        end
    end

    // Load wins over drain, so a simultaneous accept and consume produces no bubble.
    always_ff @(posedge clk) begin
        if (com_rst) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
        end else if (accept && emit) begin
            out_valid_q <= 1'b1;
            out_chan_q  <= channel_q;
            out_data_q  <= fifo_in_data;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANN; i++) begin
            fifo_in_valid_channel[i] = out_valid_q && (out_chan_q == CW'(i));
        end
    end

    assign fifo_in_data_channel = {CHANN{out_data_q}};
    assign protocol_err         = err_q;

`ifdef CHANNEL_DEMUX_STATS_EN
    logic [15:0]            drop_cnt_q;
    logic [CHANN-1:0][15:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (com_rst) begin
            drop_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            if (accept && drop && drop_cnt_q != 16'hffff) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            for (int i = 0; i < CHANN; i++) begin
                if (drain && out_chan_q == CW'(i) && word_cnt_q[i] != 16'hffff) begin
                    word_cnt_q[i] <= word_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign drop_count = drop_cnt_q;
    assign word_count = word_cnt_q;
`endif

endmodule

// File: tb/tb_channel_demultiplexer.sv
// Directed testbench for channel_demultiplexer: routing, escape, backpressure, channel switch, errors, reset.
module tb_channel_demultiplexer;

    logic          clk = 1'b0;
    logic          com_rst;
    logic          fifo_in_valid;
    logic          fifo_in_ready;
    logic [15:0]   fifo_in_data;
    logic [7:0]    fifo_in_valid_channel;
    logic [7:0]    fifo_in_ready_channel;
    logic [127:0]  fifo_in_data_channel;
    logic          protocol_err;
`ifdef CHANNEL_DEMUX_STATS_EN
    logic [15:0]   drop_count;
    logic [127:0]  word_count;
`endif

    channel_demultiplexer #(.WIDTH(16), .CHANN(8)) dut (
        .clk                   (clk),
        .com_rst               (com_rst),
        .fifo_in_valid         (fifo_in_valid),
        .fifo_in_ready         (fifo_in_ready),
        .fifo_in_data          (fifo_in_data),
        .fifo_in_valid_channel (fifo_in_valid_channel),
        .fifo_in_ready_channel (fifo_in_ready_channel),
        .fifo_in_data_channel  (fifo_in_data_channel),
        .protocol_err          (protocol_err)
`ifdef CHANNEL_DEMUX_STATS_EN
        ,
        .drop_count            (drop_count),
        .word_count            (word_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          chan;
        logic [15:0] data;
        int          cyc;
    } rec_t;

    rec_t got[$];
    int   cyc = 0;
    int   err_pulses = 0;
    int   valid_seen = 0;
    int   overlap = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are logged half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!com_rst) begin
            for (int i = 0; i < 8; i++) begin
                if (fifo_in_valid_channel[i] && fifo_in_ready_channel[i])
                    got.push_back('{i, fifo_in_data_channel[i*16 +: 16], cyc});
            end
            if (protocol_err) err_pulses++;
            if (fifo_in_valid_channel != 8'h00) valid_seen++;
            if ($countones(fifo_in_valid_channel) > 1) overlap++;
        end
    end

    task automatic clear_log();
        got.delete();
        err_pulses = 0;
        valid_seen = 0;
        overlap    = 0;
    endtask

    task automatic do_reset();
        com_rst               = 1'b1;
        fifo_in_valid         = 1'b0;
        fifo_in_data          = 16'h0000;
        fifo_in_ready_channel = 8'hff;
        repeat (2) @(posedge clk);
        #1;
        com_rst = 1'b0;
        clear_log();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; returns at posedge+1 after the word has been accepted.
    task automatic send_word(input logic [15:0] d);
        int   waited = 0;
        logic acc    = 1'b0;
        fifo_in_valid = 1'b1;
        fifo_in_data  = d;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = fifo_in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        fifo_in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles, required acceptance", d, waited);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (fifo_in_ready !== 1'b1 || fifo_in_valid_channel !== 8'h00 || protocol_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: ready=%b valid=%h err=%b, required ready=1 valid=00 err=0",
                     fifo_in_ready, fifo_in_valid_channel, protocol_err);
        end
        n_cmp++;
        if (fifo_in_data_channel !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_data: data=%h, required 0", fifo_in_data_channel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int          ec[2] = '{2, 2};
        logic [15:0] ed[2] = '{16'h1234, 16'h5678};
        do_reset();
        send_word(16'hc001);
        send_word(16'hab02);
        send_word(16'h1234);
        send_word(16'h5678);
        idle(4);
        n_cmp++;
        if (got.size() !== 2) begin
            n_bad++;
            $display("FAIL basic_count: got %0d words, required 2", got.size());
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (got.size() <= k || got[k].chan !== ec[k] || got[k].data !== ed[k]) begin
                n_bad++;
                $display("FAIL basic_word%0d: got ch%0d %h, required ch%0d %h", k,
                         (got.size() > k) ? got[k].chan : -1, (got.size() > k) ? got[k].data : 16'hxxxx, ec[k], ed[k]);
            end
        end
        n_cmp++;
        if (got.size() == 2 && got[1].cyc - got[0].cyc !== 1) begin
            n_bad++;
            $display("FAIL basic_b2b: cycle gap %0d, required 1", got[1].cyc - got[0].cyc);
        end
        n_cmp++;
        if (err_pulses !== 0) begin
            n_bad++;
            $display("FAIL basic_err: %0d pulses, required 0", err_pulses);
        end
`ifdef CHANNEL_DEMUX_STATS_EN
        n_cmp++;
        if (word_count[2*16 +: 16] !== 16'd2 || drop_count !== 16'd0) begin
            n_bad++;
            $display("FAIL basic_stats: word_count[2]=%0d drop=%0d, required 2 and 0", word_count[2*16 +: 16], drop_count);
        end
`endif
    endtask

    task automatic test_escape();
        int          ec[2] = '{1, 1};
        logic [15:0] ed[2] = '{16'hc001, 16'h0042};
        do_reset();
        send_word(16'hc001);
        send_word(16'hab01);
        send_word(16'hc001);
        send_word(16'hc001);
        send_word(16'h0042);
        idle(4);
        n_cmp++;
        if (got.size() !== 2 || err_pulses !== 0) begin
            n_bad++;
            $display("FAIL escape_count: %0d words %0d errors, required 2 words 0 errors", got.size(), err_pulses);
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (got.size() <= k || got[k].chan !== ec[k] || got[k].data !== ed[k]) begin
                n_bad++;
                $display("FAIL escape_word%0d: got ch%0d %h, required ch%0d %h", k,
                         (got.size() > k) ? got[k].chan : -1, (got.size() > k) ? got[k].data : 16'hxxxx, ec[k], ed[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_word(16'hc001);
        send_word(16'hab03);
        fifo_in_ready_channel[3] = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) send_word(16'(k));
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (fifo_in_ready !== 1'b0 || fifo_in_valid_channel[3] !== 1'b1 ||
                        fifo_in_data_channel[3*16 +: 16] !== 16'h0001) begin
                        n_bad++;
                        $display("FAIL stall_hold%0d: ready=%b valid3=%b data=%h, required ready=0 valid3=1 data=0001",
                                 k, fifo_in_ready, fifo_in_valid_channel[3], fifo_in_data_channel[3*16 +: 16]);
                    end
                end
                @(posedge clk);
                #1;
                fifo_in_ready_channel[3] = 1'b1;
            end
        join
        idle(4);
        n_cmp++;
        if (got.size() !== 4) begin
            n_bad++;
            $display("FAIL stall_count: got %0d words, required 4", got.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got.size() <= k || got[k].chan !== 3 || got[k].data !== 16'(k + 1)) begin
                n_bad++;
                $display("FAIL stall_word%0d: got ch%0d %h, required ch3 %h", k,
                         (got.size() > k) ? got[k].chan : -1, (got.size() > k) ? got[k].data : 16'hxxxx, 16'(k + 1));
            end
        end
    endtask

    task automatic test_switch();
        int          ec[2] = '{0, 5};
        logic [15:0] ed[2] = '{16'haaaa, 16'hbbbb};
        do_reset();
        fifo_in_ready_channel[0] = 1'b0;
        fork
            begin
                send_word(16'hc001);
                send_word(16'hab00);
                send_word(16'haaaa);
                send_word(16'hc001);
                send_word(16'hab05);
                send_word(16'hbbbb);
            end
            begin
                int w = 0;
                while (!fifo_in_valid_channel[0] && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                n_cmp++;
                if (w >= 50) begin
                    n_bad++;
                    $display("FAIL switch_wait: channel 0 valid not seen within 50 cycles, required presentation");
                end
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (fifo_in_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL switch_stall%0d: ready=%b, required 0", k, fifo_in_ready);
                    end
                end
                @(posedge clk);
                #1;
                fifo_in_ready_channel[0] = 1'b1;
            end
        join
        idle(4);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (got.size() <= k || got[k].chan !== ec[k] || got[k].data !== ed[k]) begin
                n_bad++;
                $display("FAIL switch_word%0d: got ch%0d %h, required ch%0d %h", k,
                         (got.size() > k) ? got[k].chan : -1, (got.size() > k) ? got[k].data : 16'hxxxx, ec[k], ed[k]);
            end
        end
        n_cmp++;
        if (overlap !== 0 || err_pulses !== 0 || got.size() !== 2) begin
            n_bad++;
            $display("FAIL switch_clean: overlap=%0d err=%0d words=%0d, required 0 0 2", overlap, err_pulses, got.size());
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_word(16'h1111);
        send_word(16'hc001);
        send_word(16'habff);
        send_word(16'hc001);
        send_word(16'h9999);
        idle(3);
        n_cmp++;
        if (err_pulses !== 3 || valid_seen !== 0) begin
            n_bad++;
            $display("FAIL err_pulses: %0d pulses valid_cycles=%0d, required 3 and 0", err_pulses, valid_seen);
        end
        // A plain data word must now be discarded as unselected.
        send_word(16'h3333);
        idle(3);
        n_cmp++;
        if (err_pulses !== 4 || valid_seen !== 0) begin
            n_bad++;
            $display("FAIL err_unselected: %0d pulses valid_cycles=%0d, required 4 and 0", err_pulses, valid_seen);
        end
    endtask

`ifdef CHANNEL_DEMUX_STATS_EN
    task automatic test_stats();
        do_reset();
        send_word(16'h1111);
        send_word(16'hc001);
        send_word(16'habff);
        send_word(16'h2222);
        send_word(16'hc001);
        send_word(16'h9999);
        idle(3);
        n_cmp++;
        if (drop_count !== 16'd2) begin
            n_bad++;
            $display("FAIL stats_drop: drop_count=%0d, required 2", drop_count);
        end
        n_cmp++;
        if (word_count !== 128'h0 || err_pulses !== 4) begin
            n_bad++;
            $display("FAIL stats_words: word_count=%h err=%0d, required 0 and 4", word_count, err_pulses);
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        fifo_in_ready_channel[1] = 1'b0;
        send_word(16'hc001);
        send_word(16'hab01);
        send_word(16'h7777);
        @(negedge clk);
        n_cmp++;
        if (fifo_in_valid_channel !== 8'h02) begin
            n_bad++;
            $display("FAIL rstmid_pending: valid=%h, required 02", fifo_in_valid_channel);
        end
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (fifo_in_valid_channel !== 8'h00 || fifo_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_drop: valid=%h ready=%b, required 00 and 1", fifo_in_valid_channel, fifo_in_ready);
        end
        @(posedge clk);
        #1;
        send_word(16'hc001);
        send_word(16'hab01);
        send_word(16'hc001);
        do_reset();
        send_word(16'hab01);
        send_word(16'h4444);
        idle(3);
        n_cmp++;
        if (err_pulses !== 2 || got.size() !== 0) begin
            n_bad++;
            $display("FAIL rstmid_ctrl: err=%0d words=%0d, required 2 and 0", err_pulses, got.size());
        end
    endtask

    initial begin
        com_rst               = 1'b1;
        fifo_in_valid         = 1'b0;
        fifo_in_data          = 16'h0000;
        fifo_in_ready_channel = 8'hff;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_escape();
        test_backpressure();
        test_switch();
        test_errors();
`ifdef CHANNEL_DEMUX_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
